snk_checker: RTL
================

Name: snk_checker

Overview:
- Traffic sink and checker at a NoC router egress port; the receiving end of the per-source traffic-generator protocol.
- Accepts beats, decodes the packed fields {src_node, dst_node, id, seq}, and checks routing and per-source sequence continuity.
- Counts accepted beats, optionally applies pseudo-random backpressure, and raises done and sticky error flags for the testbench.

Parameters:
- WIDTH, 32, beat width.
- N, 16, number of NoC nodes.
- N_ADDR_WIDTH, $clog2(N), node-address field width.
- NODE, 0, router index this sink is attached to; expected dst_node.
- NUM_SRC, 4, number of source IDs tracked; legal IDs are 0..NUM_SRC-1.
- DONE_COUNT, 100, beats required per tracked ID before done.
- BP_EN, 0: 0 = ready_out always high; 1 = LFSR-driven backpressure.
- LFSR_SEED, 16'hACE1, backpressure LFSR seed; must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- data_in  in  WIDTH  beat {src_node[N_ADDR_WIDTH], dst_node[N_ADDR_WIDTH], id[8], seq[SEQ_W]}, SEQ_W = WIDTH-2*N_ADDR_WIDTH-8.
- dest_in  in  N_ADDR_WIDTH  sideband destination.
- valid_in  in  1  beat valid.
- ready_out  out  1  sink can accept.
- done  out  1  all tracked IDs reached DONE_COUNT.
- error  out  1  sticky, any check failed.
- err_code  out  2  first error: 0 none, 1 misroute, 2 bad id, 3 sequence.
- pkt_count  out  16  total accepted beats, saturating at 16'hFFFF.

Behaviour:
- Reset: clk and rst are as already decided; rst is synchronous, active-high.
  - Applies to all outputs, which are registered.
  - Reset values: ready_out=0, done=0, error=0, err_code=0, pkt_count=0.
  - All expected_seq[i]=1 (a source's first beat carries seq 1); all per-ID counters=0; LFSR=LFSR_SEED; FSM=WAIT.
  - Reset mid-operation discards all state immediately; a beat presented during the reset cycle is not accepted.
- FSM states:
  - WAIT: one cycle after reset deassertion, ready_out=0; next state RUN.
  - RUN: ready_out = BP_EN ? (lfsr[1:0]!=2'b00) : 1; the LFSR advances every RUN cycle.
  - DONE: entered when every per-ID counter >= DONE_COUNT. ready_out stays as in RUN so upstream is not deadlocked. Beats are still accepted and checked. FSM stays in DONE until rst.
- Transfer: occurs when valid_in && ready_out in the same cycle.
  - The source must hold data_in/dest_in while valid_in && !ready_out.
  - No action when valid_in=0.
- Checks on each transfer (registered; error, err_code and counts update the cycle after the transfer):
  - Misroute: dst_node != NODE, or dest_in != NODE.
  - Bad id: id >= NUM_SRC.
    - Bad-id beats update no per-ID state.
    - They still increment pkt_count.
  - Sequence: seq != expected_seq[id].
    - On any good-ID beat, set expected_seq[id] <= seq+1 mod 2^SEQ_W, so the checker resynchronises after one error report.
    - Wrap from all-ones to 0 is legal.
  - Priority when several checks fail on one beat: misroute > bad id > sequence.
- err_code latches only the first error; error stays 1 until rst.
- Counters:
  - Per-ID counters saturate at DONE_COUNT.
  - The per-ID counter increments on every good-ID transfer, including beats with sequence errors.
  - pkt_count saturates at 16'hFFFF.
- done: registered; rises one cycle after the transfer that completes the final ID. With NUM_SRC=1, done depends only on ID 0.
- Backpressure LFSR: 16-bit Fibonacci, taps 16,14,13,11. It never stalls for more than 15 consecutive cycles given the nonzero seed.

Optional Feature:
- SNK_TRACE_EN
- Defined: simulation-only trace, excluded from synthesis with translate off/on. The trace file is reports/lynx_trace.txt, opened at time 0 and closed in a final block. On each transfer, $fdisplay and $display print:
  "SNK=<NODE>; time=<t>; from=<src_node>; to=<dst_node>; id=<id>; data=<seq>; err=<code>;"
- Undefined: no file I/O or display; functional behaviour is identical.

Decomposition:
- Package lynx_bfm_pkg:
  - seq_width(WIDTH,N_ADDR_WIDTH) function.
  - Field-extraction functions.
  - typedef enum logic[1:0] snk_err_e {ERR_NONE, ERR_ROUTE, ERR_ID, ERR_SEQ}.
  - typedef enum logic[1:0] snk_state_e {S_WAIT, S_RUN, S_DONE}.
- Sub-module lfsr16: inputs clk, rst, en; parameter SEED; output q[15:0]. It is reusable by future source BFMs.

Test Plan:
- Reset then BP_EN=0 -> ready_out=0 for one cycle, then 1. 100 in-order beats id0 seq1..100 dst=NODE -> pkt_count=100, error=0, done=0 (NUM_SRC=2).
- NUM_SRC=2, DONE_COUNT=100; interleave id0/id1 to 100 each -> done=1 exactly one cycle after the 200th transfer; a 201st beat is accepted, pkt_count=201.
- id0 seq 1,2,4,5 -> error=1, err_code=3 the cycle after seq 4; the seq 5 beat causes no new change; pkt_count=4.
- Beat with dst_node=NODE+1 and id=7 (NUM_SRC=4) -> err_code=1 (misroute priority). A later seq error leaves err_code=1.
- SEQ_W wrap: preload id0 at seq 2^SEQ_W-1, then send seq 0 -> no error.
- BP_EN=1 with valid_in held high and data stable during stalls -> no beat lost or duplicated; pkt_count equals ready&&valid cycles. Assert rst mid-burst -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/lynx_bfm_pkg.sv
// Shared types and helpers for the NoC traffic BFMs (sources and sinks).
// Beat layout, MSB to LSB: {src_node, dst_node, id[8], seq[SEQ_W]}.
package lynx_bfm_pkg;

    localparam int ID_W = 8;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ROUTE = 2'd1,
        ERR_ID    = 2'd2,
        ERR_SEQ   = 2'd3
    } snk_err_e;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } snk_state_e;

    // Width of the sequence field left over after the node and id fields.
    function automatic int seq_width(input int width, input int naw);
        return width - 2 * naw - ID_W;
    endfunction

    // Field extractors take the beat zero-extended to 64 bits and return
    // the field zero-extended to 32 bits; callers cast to the field width.
    function automatic logic [31:0] field_seq(input logic [63:0] d, input int seq_w);
        return 32'(d & ((64'd1 << seq_w) - 64'd1));
    endfunction

    function automatic logic [31:0] field_id(input logic [63:0] d, input int seq_w);
        return 32'((d >> seq_w) & 64'hFF);
    endfunction

    function automatic logic [31:0] field_dst(input logic [63:0] d, input int seq_w, input int naw);
        return 32'((d >> (seq_w + ID_W)) & ((64'd1 << naw) - 64'd1));
    endfunction

    function automatic logic [31:0] field_src(input logic [63:0] d, input int seq_w, input int naw);
        return 32'((d >> (seq_w + ID_W + naw)) & ((64'd1 << naw) - 64'd1));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (maximal length).
// Advances once per cycle while en is high; SEED must be nonzero.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];
    assign q    = r_q;

    // Shift register state: reload seed on reset, shift in feedback when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= SEED;
        end else if (en) begin
            r_q <= {r_q[14:0], w_fb};
        end else begin
            r_q <= r_q;
        end
    end

endmodule

// File: rtl/snk_checker.sv
// Egress traffic sink/checker: accepts beats, checks routing, id range and
// per-source sequence continuity, counts beats and flags completion.
// Optional build macro: SNK_TRACE_EN (simulation trace of every transfer).
module snk_checker
    import lynx_bfm_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter int          N            = 16,
    parameter int          N_ADDR_WIDTH = $clog2(N),
    parameter int          NODE         = 0,
    parameter int          NUM_SRC      = 4,
    parameter int          DONE_COUNT   = 100,
    parameter int          BP_EN        = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        data_in,
    input  logic [N_ADDR_WIDTH-1:0] dest_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [15:0]             pkt_count
);

    localparam int SEQ_W = seq_width(WIDTH, N_ADDR_WIDTH);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(DONE_COUNT + 1);

    snk_state_e       r_state;
    logic             r_ready;
    logic             r_done;
    logic             r_error;
    snk_err_e         r_err_code;
    logic [15:0]      r_pkt_count;
    logic [SEQ_W-1:0] r_exp_seq [NUM_SRC];
    logic [CNT_W-1:0] r_cnt     [NUM_SRC];

    logic [63:0]      w_data_ext;
    logic [31:0]      w_dst_f;
    logic [31:0]      w_id_f;
    logic [31:0]      w_seq_f;
    logic [SEQ_W-1:0] w_seq;
    logic [IDX_W-1:0] w_idx;
    logic [SEQ_W-1:0] w_exp_cur;
    logic             w_xfer;
    logic             w_misroute;
    logic             w_bad_id;
    logic             w_seq_bad;
    snk_err_e         w_code;
    logic [CNT_W-1:0] w_cnt_nxt [NUM_SRC];
    logic             w_all_done;
    logic [15:0]      w_lfsr_q;
    logic             w_bp_ready;
    logic             w_unused;

    assign w_data_ext = 64'(data_in);
    assign w_dst_f    = field_dst(w_data_ext, SEQ_W, N_ADDR_WIDTH);
    assign w_id_f     = field_id(w_data_ext, SEQ_W);
    assign w_seq_f    = field_seq(w_data_ext, SEQ_W);
    assign w_seq      = SEQ_W'(w_seq_f);
    assign w_idx      = IDX_W'(w_id_f);

    assign w_xfer     = valid_in && r_ready;
    assign w_misroute = (w_dst_f != 32'(NODE)) || (dest_in != N_ADDR_WIDTH'(NODE));
    assign w_bad_id   = (w_id_f >= 32'(NUM_SRC));
    assign w_seq_bad  = !w_bad_id && (w_seq != w_exp_cur);

    // Backpressure holds ready low when the two low LFSR bits are both zero.
    assign w_bp_ready = (BP_EN != 0) ? (w_lfsr_q[1:0] != 2'b00) : 1'b1;
    assign w_unused   = &{1'b0, w_lfsr_q[15:2]};

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (r_state != S_WAIT),
        .q   (w_lfsr_q)
    );

    // Look up the expected sequence number for the beat's id without indexing out of range.
    always_comb begin
        w_exp_cur = r_exp_seq[0];
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(w_idx) == i) begin
                w_exp_cur = r_exp_seq[i];
            end else begin
                w_exp_cur = w_exp_cur;
            end
        end
    end

    // Classify the current beat; routing beats id range, which beats sequence.
    always_comb begin
        w_code = ERR_NONE;
        if (w_misroute) begin
            w_code = ERR_ROUTE;
        end else if (w_bad_id) begin
            w_code = ERR_ID;
        end else if (w_seq_bad) begin
            w_code = ERR_SEQ;
        end else begin
            w_code = ERR_NONE;
        end
    end

    // Next per-id counts (saturating) and the all-ids-complete condition they imply.
    always_comb begin
        w_all_done = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_xfer && !w_bad_id && (int'(w_idx) == i) && (r_cnt[i] < CNT_W'(DONE_COUNT))) begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
            if (w_cnt_nxt[i] < CNT_W'(DONE_COUNT)) begin
                w_all_done = 1'b0;
            end else begin
                w_all_done = w_all_done;
            end
        end
    end

    // Control FSM, checker state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_WAIT;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_pkt_count <= 16'd0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_exp_seq[i] <= SEQ_W'(1);
                r_cnt[i]     <= CNT_W'(0);
            end
        end else begin
            case (r_state)
                S_WAIT: begin
                    r_state <= S_RUN;
                    r_ready <= w_bp_ready;
                end
                S_RUN: begin
                    r_ready <= w_bp_ready;
                    r_state <= w_all_done ? S_DONE : S_RUN;
                end
                S_DONE: begin
                    r_ready <= w_bp_ready;
                    r_state <= S_DONE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_WAIT;
                end
            endcase

            if (w_xfer) begin
                if (r_pkt_count != 16'hFFFF) begin
                    r_pkt_count <= r_pkt_count + 16'd1;
                end
                if (w_code != ERR_NONE) begin
                    r_error <= 1'b1;
                    if (!r_error) begin
                        r_err_code <= w_code;
                    end
                end
            end

            // Every good-id beat resynchronises its source, even after a sequence error.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_xfer && !w_bad_id && (int'(w_idx) == i)) begin
                    r_exp_seq[i] <= w_seq + SEQ_W'(1);
                end
                r_cnt[i] <= w_cnt_nxt[i];
            end

            r_done <= w_all_done;
        end
    end

    assign ready_out = r_ready;
    assign done      = r_done;
    assign error     = r_error;
    assign err_code  = r_err_code;
    assign pkt_count = r_pkt_count;

`ifdef SNK_TRACE_EN
    // Log every accepted beat with the error classification it received.
    always_ff @(posedge clk) begin
        if (!rst && w_xfer) begin
            $display("SNK=%0d; time=%0t; from=%0d; to=%0d; id=%0d; data=%0d; err=%0d;",
                     NODE, $time, field_src(w_data_ext, SEQ_W, N_ADDR_WIDTH), w_dst_f,
                     w_id_f, w_seq, w_code);
        end
    end
`endif

endmodule
